// File: rtl/cdb_scheduler_pkg.sv
// Shared types and helpers for the CDB scheduler: result entry layout,
// the ld/st source index and small one-hot / priority-encode functions.
package cdb_pkg;

  localparam int CDB_XLEN   = 32;
  localparam int CDB_TAG_W  = 6;
  localparam int CDB_MAX_FU = 16;
  localparam int FU_LDST    = 0;

  typedef struct packed {
    logic [CDB_TAG_W-1:0] tag;
    logic [CDB_XLEN-1:0]  data;
  } cdb_entry_t;

  function automatic logic [CDB_MAX_FU-1:0] onehot(input int unsigned idx);
    onehot = CDB_MAX_FU'(1) << idx;
  endfunction

  // Lowest set bit wins; returns CDB_MAX_FU when the vector is empty.
  function automatic int unsigned first_set(input logic [CDB_MAX_FU-1:0] v);
    first_set = CDB_MAX_FU;
    for (int i = CDB_MAX_FU - 1; i >= 0; i--) begin
      if (v[i]) first_set = i;
    end
  endfunction

endpackage

// File: rtl/cdb_scheduler_if.sv
// FU result inputs and CDB broadcast outputs of the scheduler, bundled.
interface cdb_scheduler_if #(
  parameter int NUM_FU = 3,
  parameter int XLEN   = 32,
  parameter int TAG_W  = 6
);

  logic [NUM_FU-1:0]       fu_valid_i;
  logic [NUM_FU*TAG_W-1:0] fu_tag_i;
  logic [NUM_FU*XLEN-1:0]  fu_data_i;
  logic [NUM_FU-1:0]       fu_ready_o;
  logic                    cdb_valid_o;
  logic [TAG_W-1:0]        cdb_tag_o;
  logic [XLEN-1:0]         cdb_data_o;
  logic [NUM_FU-1:0]       cdb_fu_o;

  modport master (
    output fu_valid_i, fu_tag_i, fu_data_i,
    input  fu_ready_o, cdb_valid_o, cdb_tag_o, cdb_data_o, cdb_fu_o
  );

  modport slave (
    input  fu_valid_i, fu_tag_i, fu_data_i,
    output fu_ready_o, cdb_valid_o, cdb_tag_o, cdb_data_o, cdb_fu_o
  );

endinterface

// File: rtl/cdb_scheduler_fu_fifo.sv
// Per-FU result buffer: small registered FIFO whose head is always visible on dout.
module cdb_fu_fifo #(
  parameter int W     = 38,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         empty,
  output logic         full
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [W-1:0]     r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr;
  logic [PTR_W-1:0] r_rd;
  logic [CNT_W-1:0] r_cnt;
  logic             w_do_push;
  logic             w_do_pop;

  assign empty     = (r_cnt == '0);
  assign full      = (r_cnt == CNT_W'(DEPTH));
  assign w_do_push = push && !full;
  assign w_do_pop  = pop && !empty;
  assign dout      = r_mem[r_rd];

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr] <= din;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!rst || flush) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_do_push) r_wr <= r_wr + 1'b1;
      if (w_do_pop)  r_rd <= r_rd + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

endmodule

// File: rtl/cdb_scheduler.sv
// Common Data Bus scheduler: buffers FU results and broadcasts one per cycle,
// ld/st first, ALUs round-robin, with an aging override against starvation.
module cdb_scheduler
  import cdb_pkg::*;
#(
  parameter int NUM_FU       = 3,
  parameter int XLEN         = 32,
  parameter int TAG_W        = 6,
  parameter int FIFO_DEPTH   = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall_i,
  input  logic            flush_i,
  cdb_scheduler_if.slave  bus
);

  localparam int WAIT_W = $clog2(STARVE_LIMIT + 1);
  localparam int IDX_W  = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;
  localparam int ENT_W  = TAG_W + XLEN;

  logic [NUM_FU-1:0]     w_empty;
  logic [NUM_FU-1:0]     w_full;
  logic [NUM_FU-1:0]     w_ready;
  logic [NUM_FU-1:0]     w_push;
  logic [NUM_FU-1:0]     w_pop;
  logic [ENT_W-1:0]      w_head [NUM_FU];

  logic [NUM_FU-1:0]     w_starved;
  logic                  w_gnt_any;
  logic                  w_gnt_rr;
  logic [IDX_W-1:0]      w_gnt_idx;
  logic [NUM_FU-1:0]     w_gnt_oh;
  logic [CDB_MAX_FU-1:0] w_oh_full;
  logic                  w_fire;
  logic [ENT_W-1:0]      w_sel;
  int                    w_cand;

  logic [WAIT_W-1:0]     r_wait [NUM_FU];
  logic [IDX_W-1:0]      r_rr;
  logic                  r_cdb_valid;
  logic [TAG_W-1:0]      r_cdb_tag;
  logic [XLEN-1:0]       r_cdb_data;
  logic [NUM_FU-1:0]     r_cdb_fu;

  // Readiness looks only at registered occupancy, so a full FIFO refuses
  // a push even when it is being popped in the same cycle.
  assign w_ready        = rst ? ~w_full : '0;
  assign bus.fu_ready_o = w_ready;

  for (genvar g = 0; g < NUM_FU; g++) begin : g_fu
    assign w_push[g] = bus.fu_valid_i[g] && w_ready[g];

    cdb_fu_fifo #(
      .W     (ENT_W),
      .DEPTH (FIFO_DEPTH)
    ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .flush (flush_i),
      .push  (w_push[g]),
      .pop   (w_pop[g]),
      .din   ({bus.fu_tag_i[g*TAG_W +: TAG_W], bus.fu_data_i[g*XLEN +: XLEN]}),
      .dout  (w_head[g]),
      .empty (w_empty[g]),
      .full  (w_full[g])
    );
  end

  always_comb begin
    w_starved = '0;
    w_gnt_any = 1'b0;
    w_gnt_rr  = 1'b0;
    w_gnt_idx = '0;
    w_cand    = 0;
    for (int i = 0; i < NUM_FU; i++) begin
      w_starved[i] = !w_empty[i] && (r_wait[i] >= WAIT_W'(STARVE_LIMIT));
    end
    if (|w_starved) begin
      w_gnt_any = 1'b1;
      w_gnt_idx = IDX_W'(first_set(CDB_MAX_FU'(w_starved)));
    end else if (!w_empty[FU_LDST]) begin
      w_gnt_any = 1'b1;
      w_gnt_idx = IDX_W'(FU_LDST);
    end else begin
      // Search ALUs starting just after the last RR winner, never visiting FU0.
      for (int k = 1; k < NUM_FU; k++) begin
        w_cand = ((int'(r_rr) - 1 + k) % (NUM_FU - 1)) + 1;
        if (!w_gnt_any && !w_empty[w_cand]) begin
          w_gnt_any = 1'b1;
          w_gnt_rr  = 1'b1;
          w_gnt_idx = IDX_W'(w_cand);
        end
      end
    end
  end

  assign w_fire    = w_gnt_any && !stall_i && !flush_i && rst;
  assign w_oh_full = onehot(32'(w_gnt_idx));
  assign w_gnt_oh  = w_oh_full[NUM_FU-1:0];
  assign w_pop     = w_fire ? w_gnt_oh : '0;
  assign w_sel     = w_head[w_gnt_idx];

  // CDB broadcast stage
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_cdb_valid <= 1'b0;
      r_cdb_tag   <= '0;
      r_cdb_data  <= '0;
      r_cdb_fu    <= '0;
      r_rr        <= IDX_W'(NUM_FU - 1);
      for (int i = 0; i < NUM_FU; i++) r_wait[i] <= '0;
    end else if (flush_i) begin
      r_cdb_valid <= 1'b0;
      r_cdb_tag   <= '0;
      r_cdb_data  <= '0;
      r_cdb_fu    <= '0;
      for (int i = 0; i < NUM_FU; i++) r_wait[i] <= '0;
    end else if (!stall_i) begin
      r_cdb_valid <= w_fire;
      r_cdb_fu    <= w_fire ? w_gnt_oh : '0;
      r_cdb_tag   <= w_fire ? w_sel[ENT_W-1 -: TAG_W] : '0;
      r_cdb_data  <= w_fire ? w_sel[XLEN-1:0] : '0;
      if (w_fire && w_gnt_rr) r_rr <= w_gnt_idx;
      for (int i = 0; i < NUM_FU; i++) begin
        if (w_empty[i] || w_pop[i]) begin
          r_wait[i] <= '0;
        end else if (r_wait[i] < WAIT_W'(STARVE_LIMIT)) begin
          r_wait[i] <= r_wait[i] + 1'b1;
        end
      end
    end
  end

  assign bus.cdb_valid_o = r_cdb_valid;
  assign bus.cdb_tag_o   = r_cdb_tag;
  assign bus.cdb_data_o  = r_cdb_data;
  assign bus.cdb_fu_o    = r_cdb_fu;

endmodule
